// File: rtl/csr_unit_if.sv
// Decoded system-op types and the request/response bundle between
// the system-op decoder and the CSR unit.
package csr_unit_pkg;
  typedef enum logic [2:0] {
    SYSOP_NOP    = 3'd0,
    SYSOP_RW     = 3'd1,
    SYSOP_RS     = 3'd2,
    SYSOP_RC     = 3'd3,
    SYSOP_ECALL  = 3'd4,
    SYSOP_EBREAK = 3'd5,
    SYSOP_MRET   = 3'd6
  } rv32_sysop;

  // {read, write} enables
  typedef logic [1:0] rv32_csr_access;
  localparam rv32_csr_access CSR_NOP = 2'b00;
  localparam rv32_csr_access CSR_W   = 2'b01;
  localparam rv32_csr_access CSR_R   = 2'b10;
  localparam rv32_csr_access CSR_RW  = 2'b11;
endpackage

interface csr_unit_if;
  import csr_unit_pkg::*;

  logic           i_valid;
  logic           o_ready;
  rv32_sysop      i_sysop;
  rv32_csr_access i_csr_access;
  logic           i_invalid;
  logic [11:0]    i_csr_addr;
  logic [31:0]    i_operand;
  logic [31:0]    i_pc;
  logic           o_done;
  logic [31:0]    o_rdata;
  logic           o_redirect;
  logic [31:0]    o_target_pc;

  modport master (
    output i_valid, i_sysop, i_csr_access, i_invalid, i_csr_addr, i_operand, i_pc,
    input  o_ready, o_done, o_rdata, o_redirect, o_target_pc
  );

  modport slave (
    input  i_valid, i_sysop, i_csr_access, i_invalid, i_csr_addr, i_operand, i_pc,
    output o_ready, o_done, o_rdata, o_redirect, o_target_pc
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file and system-op execution stage: one op in flight,
// returns the old CSR value and a PC redirect for traps and MRET.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | decode address, read old value, compute new value and trap
// RESP   | o_done pulse; CSR/trap state commits at the end of this cycle
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  csr_unit_if.slave bus,
  input  logic      i_retire,
  input  logic      i_irq_ext,
  output logic      o_irq_pending
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t         r_state, w_next;
  logic           w_ready, w_done;

  rv32_sysop      r_sysop;
  rv32_csr_access r_acc;
  logic           r_invalid;
  logic [11:0]    r_addr;
  logic [31:0]    r_operand, r_pc;

  logic [31:0]    r_rdata, r_target, r_wdata;
  logic           r_redirect, r_trap, r_mret, r_wen;
  logic [3:0]     r_cause;
  logic [31:0]    r_tval;

  logic           r_mie, r_mpie, r_meie;
  logic [31:0]    r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [63:0]    r_mcycle, r_minstret;

  logic [31:0]    w_old, w_new, w_rdata, w_target, w_tval;
  logic           w_impl, w_csr_op, w_illegal, w_trap, w_mret, w_wen, w_redirect;
  logic [3:0]     w_cause;
  logic           w_commit, w_wr_cyc_lo, w_wr_cyc_hi, w_wr_ins_lo, w_wr_ins_hi;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.i_valid) w_next = S_ACCESS;
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sysop   <= SYSOP_NOP;
      r_acc     <= CSR_NOP;
      r_invalid <= 1'b0;
      r_addr    <= '0;
      r_operand <= '0;
      r_pc      <= '0;
    end else if (r_state == S_IDLE && bus.i_valid) begin
      r_sysop   <= bus.i_sysop;
      r_acc     <= bus.i_csr_access;
      r_invalid <= bus.i_invalid;
      r_addr    <= bus.i_csr_addr;
      r_operand <= bus.i_operand;
      r_pc      <= bus.i_pc;
    end
  end

  always_comb begin
    w_old  = '0;
    w_impl = 1'b1;
    case (r_addr)
      12'h300: w_old = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
      12'h301: w_old = MISA_VALUE;
      12'h304: w_old = {20'd0, r_meie, 11'd0};
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h343: w_old = r_mtval;
      12'h344: w_old = {20'd0, i_irq_ext, 11'd0};
      12'hB00: w_old = r_mcycle[31:0];
      12'hB80: w_old = r_mcycle[63:32];
      12'hB02: w_old = r_minstret[31:0];
      12'hB82: w_old = r_minstret[63:32];
      12'hF14: w_old = HART_ID;
      default: w_impl = 1'b0;
    endcase
  end

  always_comb begin
    case (r_sysop)
      SYSOP_RW: w_new = r_operand;
      SYSOP_RS: w_new = w_old | r_operand;
      default:  w_new = w_old & ~r_operand;
    endcase
  end

  // Decoder illegality takes priority over ECALL/EBREAK/MRET classification
  always_comb begin
    w_csr_op  = (r_sysop == SYSOP_RW) || (r_sysop == SYSOP_RS) || (r_sysop == SYSOP_RC);
    w_illegal = r_invalid
              | (w_csr_op & (|r_acc) & ~w_impl)
              | (w_csr_op & r_acc[0] & (r_addr[11:10] == 2'b11));
    w_trap    = w_illegal | (r_sysop == SYSOP_ECALL) | (r_sysop == SYSOP_EBREAK);
    w_mret    = ~w_illegal & (r_sysop == SYSOP_MRET);
    w_wen     = ~w_illegal & w_csr_op & r_acc[0];
    w_rdata   = (~w_illegal & w_csr_op & r_acc[1]) ? w_old : 32'd0;
    w_cause   = w_illegal ? 4'd2 : ((r_sysop == SYSOP_ECALL) ? 4'd11 : 4'd3);
    w_tval    = w_illegal ? 32'd0 : r_pc;
    w_redirect = w_trap | w_mret;
    w_target   = w_trap ? r_mtvec : (w_mret ? r_mepc : 32'd0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata    <= '0;
      r_target   <= '0;
      r_wdata    <= '0;
      r_redirect <= 1'b0;
      r_trap     <= 1'b0;
      r_mret     <= 1'b0;
      r_wen      <= 1'b0;
      r_cause    <= '0;
      r_tval     <= '0;
    end else if (r_state == S_ACCESS) begin
      r_rdata    <= w_rdata;
      r_target   <= w_target;
      r_wdata    <= w_new;
      r_redirect <= w_redirect;
      r_trap     <= w_trap;
      r_mret     <= w_mret;
      r_wen      <= w_wen;
      r_cause    <= w_cause;
      r_tval     <= w_tval;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtvec    <= {MTVEC_RESET[31:2], 2'b00};
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (r_state == S_RESP) begin
      if (r_trap) begin
        r_mepc   <= {r_pc[31:2], 2'b00};
        r_mcause <= {28'd0, r_cause};
        r_mtval  <= r_tval;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (r_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (r_wen) begin
        case (r_addr)
          12'h300: begin
            r_mie  <= r_wdata[3];
            r_mpie <= r_wdata[7];
          end
          12'h304: r_meie     <= r_wdata[11];
          12'h305: r_mtvec    <= {r_wdata[31:2], 2'b00};
          12'h340: r_mscratch <= r_wdata;
          12'h341: r_mepc     <= {r_wdata[31:2], 2'b00};
          12'h342: r_mcause   <= r_wdata;
          12'h343: r_mtval    <= r_wdata;
          default: ;
        endcase
      end
    end
  end

  // A CSR write to either counter half suppresses that counter's increment
  assign w_commit    = (r_state == S_RESP) & r_wen;
  assign w_wr_cyc_lo = w_commit & (r_addr == 12'hB00);
  assign w_wr_cyc_hi = w_commit & (r_addr == 12'hB80);
  assign w_wr_ins_lo = w_commit & (r_addr == 12'hB02);
  assign w_wr_ins_hi = w_commit & (r_addr == 12'hB82);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wr_cyc_lo)      r_mcycle[31:0]  <= r_wdata;
      else if (w_wr_cyc_hi) r_mcycle[63:32] <= r_wdata;
      else                  r_mcycle        <= r_mcycle + 64'd1;

      if (w_wr_ins_lo)      r_minstret[31:0]  <= r_wdata;
      else if (w_wr_ins_hi) r_minstret[63:32] <= r_wdata;
      else if (i_retire)    r_minstret        <= r_minstret + 64'd1;
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_done      = w_done;
  assign bus.o_rdata     = w_done ? r_rdata : 32'd0;
  assign bus.o_redirect  = w_done & r_redirect;
  assign bus.o_target_pc = w_done ? r_target : 32'd0;
  assign o_irq_pending   = r_mie & r_meie & i_irq_ext;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: a driver runs a behavioural CSR model and queues
// expected responses; a monitor pops and compares on every o_done.
module tb_csr_unit;
  import csr_unit_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_retire = 1'b0;
  logic i_irq_ext = 1'b0;
  logic o_irq_pending;

  csr_unit_if bus();

  csr_unit #(
    .HART_ID    (32'd0),
    .MTVEC_RESET(32'h0000_0000),
    .MISA_VALUE (32'h4000_0100)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .bus          (bus),
    .i_retire     (i_retire),
    .i_irq_ext    (i_irq_ext),
    .o_irq_pending(o_irq_pending)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] target;
    int          cyc;
    logic        chk;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   n_sent = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // behavioural machine-mode state
  logic        m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0;
    m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endfunction

  function automatic logic [31:0] csr_read(input logic [11:0] a, output logic impl);
    impl = 1'b1;
    case (a)
      12'h300: return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return 32'(m_meie) << 11;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return 32'(i_irq_ext) << 11;
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 32'd0;
      12'hF14: return 32'd0;
      default: begin impl = 1'b0; return 32'd0; end
    endcase
  endfunction

  function automatic void csr_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
      12'h304: m_meie = v[11];
      12'h305: m_mtvec = v & ~32'd3;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & ~32'd3;
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      default: ;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got o_done=1, expected no op in flight (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check32($sformatf("latency#%0d", e.id), cyc, e.cyc);
        if (e.chk) check32($sformatf("rdata#%0d", e.id), bus.o_rdata, e.rdata);
        check32($sformatf("redirect#%0d", e.id), {31'd0, bus.o_redirect}, {31'd0, e.redirect});
        if (e.redirect) check32($sformatf("target#%0d", e.id), bus.o_target_pc, e.target);
      end
    end
  end

  task automatic send(input rv32_sysop op, input logic [1:0] acc, input logic inv,
                      input logic [11:0] addr, input logic [31:0] opnd, input logic [31:0] pc,
                      input int gap, input logic ovr, input logic [31:0] ovr_val, input logic chk);
    exp_t e;
    logic [31:0] old, nv;
    logic impl, csr_op, ill;
    int n;
    @(negedge i_clk);
    if (gap > 0) begin
      bus.i_valid = 1'b0;
      repeat (gap) @(negedge i_clk);
    end
    bus.i_sysop = op; bus.i_csr_access = acc; bus.i_invalid = inv;
    bus.i_csr_addr = addr; bus.i_operand = opnd; bus.i_pc = pc;
    bus.i_valid = 1'b1;
    n = 0;
    while (!bus.o_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.o_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: o_ready stayed 0, expected 1 within 20 cycles");
      bus.i_valid = 1'b0;
      return;
    end
    e.rdata = 0; e.redirect = 0; e.target = 0; e.chk = chk; e.id = n_sent;
    e.cyc = cyc + 2;
    old = csr_read(addr, impl);
    csr_op = (op == SYSOP_RW) || (op == SYSOP_RS) || (op == SYSOP_RC);
    ill = inv || (csr_op && acc != 2'b00 && !impl) || (csr_op && acc[0] && addr[11:10] == 2'b11);
    if (ill || op == SYSOP_ECALL || op == SYSOP_EBREAK) begin
      e.redirect = 1; e.target = m_mtvec;
      m_mepc = pc & ~32'd3;
      m_mcause = ill ? 32'd2 : (op == SYSOP_ECALL ? 32'd11 : 32'd3);
      m_mtval = ill ? 32'd0 : pc;
      m_mpie = m_mie; m_mie = 0;
    end else if (op == SYSOP_MRET) begin
      e.redirect = 1; e.target = m_mepc;
      m_mie = m_mpie; m_mpie = 1;
    end else if (csr_op) begin
      if (acc[1]) e.rdata = old;
      if (acc[0]) begin
        nv = (op == SYSOP_RW) ? opnd : (op == SYSOP_RS) ? (old | opnd) : (old & ~opnd);
        csr_write(addr, nv);
      end
    end
    if (ovr) e.rdata = ovr_val;
    sb.push_back(e);
    n_sent++;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic op(input rv32_sysop s, input logic [1:0] acc, input logic [11:0] a,
                    input logic [31:0] v, input logic [31:0] pc, input int gap);
    send(s, acc, 1'b0, a, v, pc, gap, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic cnt(input rv32_sysop s, input logic [1:0] acc, input logic [11:0] a,
                     input logic [31:0] v, input int gap, input logic [31:0] exp, input logic chk);
    send(s, acc, 1'b0, a, v, 32'd0, gap, 1'b1, exp, chk);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while (!bus.o_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.o_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: o_ready stayed 0, expected 1 within 20 cycles");
    end
  endtask

  task automatic chk_irq(input logic v);
    wait_idle();
    i_irq_ext = v;
    @(negedge i_clk);
    check32("irq_pending", {31'd0, o_irq_pending}, {31'd0, m_mie & m_meie & i_irq_ext});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [11:0] addrs [14];
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
              12'h343, 12'h344, 12'hF14, 12'h7C0, 12'hB03, 12'hC00, 12'h340};
    model_reset();
    bus.i_valid = 0; bus.i_sysop = SYSOP_NOP; bus.i_csr_access = CSR_NOP; bus.i_invalid = 0;
    bus.i_csr_addr = 0; bus.i_operand = 0; bus.i_pc = 0;
    repeat (3) @(negedge i_clk);
    check32("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    check32("rst_done", {31'd0, bus.o_done}, 32'd0);
    check32("rst_rdata", bus.o_rdata, 32'd0);
    check32("rst_redirect", {31'd0, bus.o_redirect}, 32'd0);
    check32("rst_target", bus.o_target_pc, 32'd0);
    check32("rst_irq", {31'd0, o_irq_pending}, 32'd0);
    i_rst_n = 1'b1;

    // CSR read-modify-write basics
    op(SYSOP_RW, CSR_RW, 12'h340, 32'hDEAD_BEEF, 32'h100, 0);
    op(SYSOP_RS, CSR_RW, 12'h340, 32'h0000_0010, 32'h104, 0);
    op(SYSOP_RS, CSR_R,  12'h340, 32'h0, 32'h108, 1);
    op(SYSOP_RW, CSR_RW, 12'h305, 32'h8000_0103, 32'h10C, 0);
    op(SYSOP_RC, CSR_R,  12'h305, 32'h0, 32'h110, 0);
    op(SYSOP_RS, CSR_R,  12'h305, 32'h0, 32'h114, 2);
    op(SYSOP_RS, CSR_R,  12'h301, 32'h0, 32'h118, 0);

    // interrupt enable, ECALL / MRET round trip
    op(SYSOP_RS, CSR_RW, 12'h300, 32'h8, 32'h11C, 0);
    op(SYSOP_RW, CSR_RW, 12'h304, 32'h800, 32'h120, 0);
    chk_irq(1'b1);
    op(SYSOP_ECALL, CSR_NOP, 12'h000, 32'h0, 32'h200, 0);
    chk_irq(1'b1);
    op(SYSOP_RS, CSR_R, 12'h342, 32'h0, 32'h204, 0);
    op(SYSOP_RS, CSR_R, 12'h341, 32'h0, 32'h208, 0);
    op(SYSOP_RS, CSR_R, 12'h343, 32'h0, 32'h20C, 0);
    op(SYSOP_RS, CSR_R, 12'h300, 32'h0, 32'h210, 0);
    op(SYSOP_MRET, CSR_NOP, 12'h000, 32'h0, 32'h214, 0);
    op(SYSOP_RS, CSR_R, 12'h300, 32'h0, 32'h218, 0);
    chk_irq(1'b1);
    op(SYSOP_RS, CSR_R, 12'h344, 32'h0, 32'h21C, 0);

    // illegal accesses
    op(SYSOP_RW, CSR_RW, 12'hF14, 32'h1234_5678, 32'h300, 0);
    op(SYSOP_RS, CSR_R,  12'h342, 32'h0, 32'h304, 0);
    op(SYSOP_RS, CSR_R,  12'h343, 32'h0, 32'h308, 0);
    op(SYSOP_RS, CSR_R,  12'hF14, 32'h0, 32'h30C, 0);
    op(SYSOP_RW, CSR_RW, 12'h7C0, 32'h1, 32'h310, 0);
    op(SYSOP_RS, CSR_R,  12'h341, 32'h0, 32'h314, 0);
    op(SYSOP_EBREAK, CSR_NOP, 12'h000, 32'h0, 32'h318, 0);
    op(SYSOP_RS, CSR_R,  12'h342, 32'h0, 32'h31C, 0);
    send(SYSOP_NOP, CSR_NOP, 1'b1, 12'h000, 32'h0, 32'h320, 0, 1'b0, 32'd0, 1'b1);
    op(SYSOP_NOP, CSR_NOP, 12'h000, 32'h0, 32'h324, 0);
    op(SYSOP_RC, CSR_NOP, 12'h7C0, 32'h0, 32'h328, 0);

    // reset while ACCESS of a CSRRW mscratch
    @(negedge i_clk);
    bus.i_sysop = SYSOP_RW; bus.i_csr_access = CSR_RW; bus.i_invalid = 0;
    bus.i_csr_addr = 12'h340; bus.i_operand = 32'hA5A5_5A5A; bus.i_valid = 1;
    for (int n = 0; n < 20 && !bus.o_ready; n++) @(negedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    bus.i_valid = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check32("ready_after_reset", {31'd0, bus.o_ready}, 32'd1);
    op(SYSOP_RS, CSR_R, 12'h340, 32'h0, 32'h400, 0);

    // 64-bit cycle counter: carry and write-wins
    cnt(SYSOP_RW, CSR_RW, 12'hB00, 32'hFFFF_FFFF, 0, 32'd0, 1'b0);
    cnt(SYSOP_RS, CSR_R,  12'hB80, 32'h0, 0, 32'd1, 1'b1);
    cnt(SYSOP_RS, CSR_R,  12'hB00, 32'h0, 0, 32'd3, 1'b1);
    cnt(SYSOP_RS, CSR_R,  12'hB80, 32'h0, 2, 32'd1, 1'b1);
    cnt(SYSOP_RW, CSR_RW, 12'hB00, 32'h0000_1000, 0, 32'd0, 1'b0);
    cnt(SYSOP_RS, CSR_R,  12'hB00, 32'h0, 0, 32'h0000_1001, 1'b1);
    cnt(SYSOP_RW, CSR_RW, 12'hB80, 32'h55, 0, 32'd1, 1'b1);
    cnt(SYSOP_RS, CSR_R,  12'hB80, 32'h0, 0, 32'h55, 1'b1);

    // retire counter
    cnt(SYSOP_RW, CSR_RW, 12'hB02, 32'd5, 0, 32'd0, 1'b1);
    wait_idle();
    i_retire = 1'b1;
    repeat (3) @(negedge i_clk);
    i_retire = 1'b0;
    cnt(SYSOP_RS, CSR_R, 12'hB02, 32'h0, 0, 32'd8, 1'b1);
    cnt(SYSOP_RS, CSR_R, 12'hB82, 32'h0, 0, 32'd0, 1'b1);
    i_retire = 1'b1;
    cnt(SYSOP_RW, CSR_RW, 12'hB02, 32'h100, 0, 32'd0, 1'b0);
    cnt(SYSOP_RS, CSR_R,  12'hB02, 32'h0, 0, 32'h101, 1'b1);
    i_retire = 1'b0;

    // randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      int r;
      rv32_sysop s;
      r = $urandom_range(0, 19);
      if (r < 5)       s = SYSOP_RW;
      else if (r < 10) s = SYSOP_RS;
      else if (r < 14) s = SYSOP_RC;
      else if (r == 14) s = SYSOP_ECALL;
      else if (r == 15) s = SYSOP_EBREAK;
      else if (r == 16) s = SYSOP_MRET;
      else              s = SYSOP_NOP;
      send(s, 2'($urandom_range(0, 3)), (r == 18 || r == 19) ? 1'b1 : 1'b0,
           addrs[$urandom_range(0, 13)], $urandom, $urandom & ~32'd3,
           $urandom_range(0, 2), 1'b0, 32'd0, 1'b1);
      if ((i % 16) == 15) chk_irq(1'($urandom_range(0, 1)));
    end

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge i_clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
